// File: rtl/countdown_sequencer.sv
// Frame-synchronous seconds countdown feeding the countdown pixel generator.
// Counts START_SEC..0 in whole seconds, holds GO for GO_HOLD_SEC seconds, then pulses done.
module countdown_sequencer #(
    parameter int unsigned CLK_HZ      = 40_000_000,
    parameter int unsigned START_SEC   = 3,
    parameter int unsigned GO_HOLD_SEC = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       pause,
    input  logic       abort,
    input  logic       frame_tick,
    output logic [3:0] sec_1s,
    output logic       go_on,
    output logic       running,
    output logic       done
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam int unsigned HW = (GO_HOLD_SEC > 1) ? $clog2(GO_HOLD_SEC) : 1;

    localparam logic [PW-1:0] PRE_MAX     = PW'(CLK_HZ - 1);
    localparam logic [3:0]    START_DIGIT = 4'(START_SEC);
    localparam logic [HW-1:0] HOLD_INIT   = HW'(GO_HOLD_SEC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        GO    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescaler;
    logic [3:0]    sec_cnt;
    logic [HW-1:0] hold_cnt;
    logic          done_q;

    logic          active;
    logic          sec_tick;
    logic          finish;

    always_comb begin
        active   = (state == COUNT) || (state == GO);
        sec_tick = active && (prescaler == PRE_MAX) && !pause;
        finish   = (state == GO) && sec_tick && (hold_cnt == '0) && !abort;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = COUNT;
                COUNT:   if (sec_tick && (sec_cnt == '0)) state_next = GO;
                GO:      if (sec_tick && (hold_cnt == '0)) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == COUNT) || (state == GO);
        done    = done_q;
    end

    // Prescaler sits at zero in IDLE, so an accepted start always begins a full second.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescaler <= '0;
        end else if (abort || !active) begin
            prescaler <= '0;
        end else if (!pause) begin
            prescaler <= sec_tick ? '0 : prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_cnt <= START_DIGIT;
        end else if (abort || (state == IDLE) || finish) begin
            sec_cnt <= START_DIGIT;
        end else if ((state == COUNT) && sec_tick && (sec_cnt != '0)) begin
            sec_cnt <= sec_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= HOLD_INIT;
        end else if ((state == COUNT) && (state_next == GO)) begin
            hold_cnt <= HOLD_INIT;
        end else if ((state == GO) && sec_tick && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - HW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
        end
    end

    // Display copies the pre-edge state, so a same-edge state change shows up one tick later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sec_1s <= START_DIGIT;
            go_on  <= 1'b0;
        end else if (frame_tick) begin
            sec_1s <= sec_cnt;
            go_on  <= (state == GO);
        end
    end

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench for countdown_sequencer: a model based on elapsed running cycles
// pushes expected outputs each edge; a monitor pops and compares after the edge.
module tb_countdown_sequencer;

    localparam int unsigned CLK_HZ      = 10;
    localparam int unsigned START_SEC   = 3;
    localparam int unsigned GO_HOLD_SEC = 1;
    localparam int unsigned GO_AT       = (START_SEC + 1) * CLK_HZ;
    localparam int unsigned TOTAL       = (START_SEC + 1 + GO_HOLD_SEC) * CLK_HZ;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       pause;
    logic       abort;
    logic       frame_tick;
    logic [3:0] sec_1s;
    logic       go_on;
    logic       running;
    logic       done;

    countdown_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .START_SEC  (START_SEC),
        .GO_HOLD_SEC(GO_HOLD_SEC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .frame_tick(frame_tick),
        .sec_1s    (sec_1s),
        .go_on     (go_on),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Expected vector layout: {digit[3:0], go_on, running, done}
    logic [6:0] exp_q[$];

    // Reference model: progress is tracked as the number of non-paused running cycles.
    bit          m_active;
    int unsigned m_elapsed;
    logic [3:0]  m_disp_digit;
    bit          m_disp_go;
    bit          m_done;

    function automatic logic [3:0] model_digit(bit act, int unsigned el);
        if (!act || el >= GO_AT) return act ? 4'd0 : 4'(START_SEC);
        return 4'(START_SEC - el / CLK_HZ);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!reset_n) begin
                m_active     = 0;
                m_elapsed    = 0;
                m_disp_digit = 4'(START_SEC);
                m_disp_go    = 0;
                m_done       = 0;
            end else begin
                logic [3:0] pre_digit;
                bit         pre_go;
                pre_digit = model_digit(m_active, m_elapsed);
                pre_go    = m_active && (m_elapsed >= GO_AT);
                m_done    = 0;
                if (abort) begin
                    m_active  = 0;
                    m_elapsed = 0;
                end else if (!m_active) begin
                    if (start) begin
                        m_active  = 1;
                        m_elapsed = 0;
                    end
                end else if (!pause) begin
                    m_elapsed++;
                    if (m_elapsed == TOTAL) begin
                        m_active  = 0;
                        m_elapsed = 0;
                        m_done    = 1;
                    end
                end
                if (frame_tick) begin
                    m_disp_digit = pre_digit;
                    m_disp_go    = pre_go;
                end
            end
            exp_q.push_back({m_disp_digit, m_disp_go, m_active, m_done});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty t=%0t: no expected entry for output sample", $time);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if ({sec_1s, go_on, running, done} !== e) begin
                    miscompares++;
                    $display("FAIL cycle_outputs t=%0t: got sec_1s=%0d go_on=%0b running=%0b done=%0b, want sec_1s=%0d go_on=%0b running=%0b done=%0b",
                             $time, sec_1s, go_on, running, done, e[6:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // 0: frame_tick every 4 cycles, 1: never, 2: random
    int          ft_mode = 0;
    int unsigned fcnt    = 0;

    task automatic tick(input bit s, input bit a);
        @(negedge clk);
        start = s;
        abort = a;
        case (ft_mode)
            0:       frame_tick = (fcnt % 4 == 0);
            1:       frame_tick = 1'b0;
            default: frame_tick = ($urandom_range(0, 3) == 0);
        endcase
        fcnt++;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        pause      = 1'b0;
        abort      = 1'b0;
        frame_tick = 1'b0;
        idle(3);
        reset_n = 1'b1;

        // Idle with no start, pause toggling has no effect
        idle(10);
        pause = 1'b1;
        idle(6);
        pause = 1'b0;

        // Full run
        tick(1, 0);
        idle(60);

        // Pause during digit 2
        tick(1, 0);
        idle(15);
        pause = 1'b1;
        idle(25);
        pause = 1'b0;
        idle(50);

        // Abort at digit 1, then start+abort together from IDLE
        tick(1, 0);
        idle(24);
        tick(0, 1);
        idle(10);
        tick(1, 1);
        idle(8);

        // Start while counting is ignored
        tick(1, 0);
        idle(15);
        tick(1, 0);
        idle(50);

        // Start while paused in IDLE
        pause = 1'b1;
        tick(1, 0);
        idle(7);
        pause = 1'b0;
        idle(55);

        // Asynchronous reset in the middle of GO
        tick(1, 0);
        idle(45);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({sec_1s, go_on, running, done} !== {4'(START_SEC), 3'b000}) begin
            miscompares++;
            $display("FAIL async_reset: got sec_1s=%0d go_on=%0b running=%0b done=%0b, want sec_1s=%0d go_on=0 running=0 done=0",
                     sec_1s, go_on, running, done, START_SEC);
        end
        idle(1);
        reset_n = 1'b1;
        idle(4);

        // No frame ticks during a full run
        ft_mode = 1;
        tick(1, 0);
        idle(60);
        ft_mode = 0;
        idle(8);

        // Randomized traffic
        ft_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) pause = ~pause;
            tick($urandom_range(0, 24) == 0, $urandom_range(0, 119) == 0);
        end
        pause   = 1'b0;
        ft_mode = 0;
        idle(60);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
